// File: rtl/img_rsz_ctrl.sv
// img_rsz_ctrl: frame sequencer for the image resizer; indexes block-sum accumulation
// during the pixel raster, then scans the resized buffer out with a valid/ready handshake.
module img_rsz_ctrl #(
   parameter int IMG_WIDTH_MAX_SIZE  = 1024,
   parameter int IMG_HEIGHT_MAX_SIZE = 1024,
   parameter int RSZ_IMG_WIDTH_SIZE  = 8,
   parameter int RSZ_IMG_HEIGHT_SIZE = 8,
   localparam int BWM = $clog2(IMG_WIDTH_MAX_SIZE) - $clog2(RSZ_IMG_WIDTH_SIZE),
   localparam int BHM = $clog2(IMG_HEIGHT_MAX_SIZE) - $clog2(RSZ_IMG_HEIGHT_SIZE),
   localparam int LW  = $clog2(((BWM > BHM) ? BWM : BHM) + 1),
   localparam int CW  = $clog2(RSZ_IMG_WIDTH_SIZE),
   localparam int RW  = $clog2(RSZ_IMG_HEIGHT_SIZE)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [LW-1:0] cfg_blk_w_log2,
   input  logic [LW-1:0] cfg_blk_h_log2,
   output logic          busy,
   input  logic          pxl_vld,
   output logic          pxl_rdy,
   output logic          acc_en,
   output logic          acc_clr,
   output logic [RW-1:0] acc_row,
   output logic [CW-1:0] acc_col,
   output logic          fwd_vld,
   input  logic          fwd_rdy,
   output logic [RW-1:0] fwd_row,
   output logic [CW-1:0] fwd_col,
   output logic          fwd_last,
   output logic [LW:0]   fwd_shift,
   output logic          frame_done
);
   localparam int XW = $clog2(IMG_WIDTH_MAX_SIZE);
   localparam int YW = $clog2(IMG_HEIGHT_MAX_SIZE);

   typedef enum logic [1:0] {IDLE, ACC, FWD} stateT;

   stateT state, stateNext;
   logic [XW-1:0] x, wMask;
   logic [YW-1:0] y, hMask;
   logic [LW-1:0] bw, bh;
   logic [XW:0] wDim;
   logic [YW:0] hDim;
   logic xLast, yLast, colLast, rowLast, fwdHs;

   assign wDim = (XW+1)'(RSZ_IMG_WIDTH_SIZE) << bw;
   assign hDim = (YW+1)'(RSZ_IMG_HEIGHT_SIZE) << bh;
   assign xLast = x == XW'(wDim - 1'b1);
   assign yLast = y == YW'(hDim - 1'b1);
   assign wMask = ~({XW{1'b1}} << bw);
   assign hMask = ~({YW{1'b1}} << bh);

   assign busy = state != IDLE;
   assign pxl_rdy = state == ACC;
   assign acc_en = pxl_vld && pxl_rdy;
   assign acc_clr = acc_en && (x & wMask) == '0 && (y & hMask) == '0;
   assign acc_col = CW'(x >> bw);
   assign acc_row = RW'(y >> bh);
   assign fwd_vld = state == FWD;
   assign colLast = fwd_col == CW'(RSZ_IMG_WIDTH_SIZE - 1);
   assign rowLast = fwd_row == RW'(RSZ_IMG_HEIGHT_SIZE - 1);
   assign fwd_last = fwd_vld && colLast && rowLast;
   assign fwdHs = fwd_vld && fwd_rdy;
   assign fwd_shift = (LW+1)'(bw) + (LW+1)'(bh);

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (start) stateNext = ACC;
         ACC: if (acc_en && xLast && yLast) stateNext = FWD;
         FWD: if (fwdHs && fwd_last) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         x <= '0;
         y <= '0;
         bw <= '0;
         bh <= '0;
         fwd_row <= '0;
         fwd_col <= '0;
         frame_done <= 1'b0;
      end else begin
         state <= stateNext;
         frame_done <= fwdHs && fwd_last;
         if (state == IDLE && start) begin
            // out-of-range block sizes saturate at the largest that fits the source
            bw <= (cfg_blk_w_log2 > LW'(BWM)) ? LW'(BWM) : cfg_blk_w_log2;
            bh <= (cfg_blk_h_log2 > LW'(BHM)) ? LW'(BHM) : cfg_blk_h_log2;
            x <= '0;
            y <= '0;
         end
         if (acc_en) begin
            x <= xLast ? '0 : x + 1'b1;
            if (xLast) y <= yLast ? '0 : y + 1'b1;
         end
         if (fwdHs) begin
            fwd_col <= colLast ? '0 : fwd_col + 1'b1;
            if (colLast) fwd_row <= rowLast ? '0 : fwd_row + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_img_rsz_ctrl.sv
// tb_img_rsz_ctrl: directed frames against a raster/beat-count model of the sequencer,
// on a 32x32 max source with an 8x8 resized grid so clamping is reachable.
module tb_img_rsz_ctrl;
   logic clk = 0, rst_n = 0, start = 0, pxl_vld = 0, fwd_rdy = 0;
   logic [1:0] cfg_blk_w_log2 = 0, cfg_blk_h_log2 = 0;
   logic busy, pxl_rdy, acc_en, acc_clr, fwd_vld, fwd_last, frame_done;
   logic [2:0] acc_row, acc_col, fwd_row, fwd_col, fwd_shift;

   int checks = 0, errors = 0;
   int vldMode = 0, rdyMode = 0;
   int mPhase = 0, mK = 0, mB = 0, mBw = 0, mBh = 0, px, py, w, h;
   bit mDone = 0;
   int nAccEn = 0, nAccClr = 0, nFwdHs = 0, lastAccEn = 0, lastAccClr = 0, lastFwdHs = 0;

   img_rsz_ctrl #(
      .IMG_WIDTH_MAX_SIZE(32), .IMG_HEIGHT_MAX_SIZE(32),
      .RSZ_IMG_WIDTH_SIZE(8), .RSZ_IMG_HEIGHT_SIZE(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_blk_w_log2(cfg_blk_w_log2), .cfg_blk_h_log2(cfg_blk_h_log2),
      .busy(busy), .pxl_vld(pxl_vld), .pxl_rdy(pxl_rdy), .acc_en(acc_en), .acc_clr(acc_clr),
      .acc_row(acc_row), .acc_col(acc_col), .fwd_vld(fwd_vld), .fwd_rdy(fwd_rdy),
      .fwd_row(fwd_row), .fwd_col(fwd_col), .fwd_last(fwd_last), .fwd_shift(fwd_shift),
      .frame_done(frame_done)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      pxl_vld = vldMode != 0 ? ($urandom % 3 != 0) : 1'b1;
      fwd_rdy = rdyMode != 0 ? 1'($urandom % 2) : 1'b1;
   end

   // Model: a frame is W*H accepted pixels in raster order, then 64 forward beats in row-major order.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         mPhase = 0; mK = 0; mB = 0; mBw = 0; mBh = 0; mDone = 0;
         chk("rst_busy", busy, 0); chk("rst_pxl_rdy", pxl_rdy, 0);
         chk("rst_acc_en", acc_en, 0); chk("rst_acc_clr", acc_clr, 0);
         chk("rst_fwd_vld", fwd_vld, 0); chk("rst_fwd_last", fwd_last, 0);
         chk("rst_frame_done", frame_done, 0); chk("rst_fwd_shift", fwd_shift, 0);
         chk("rst_acc_row", acc_row, 0); chk("rst_acc_col", acc_col, 0);
         chk("rst_fwd_row", fwd_row, 0); chk("rst_fwd_col", fwd_col, 0);
      end else begin
         w = 8 << mBw;
         h = 8 << mBh;
         px = mK % w;
         py = mK / w;
         chk("busy", busy, int'(mPhase != 0));
         chk("pxl_rdy", pxl_rdy, int'(mPhase == 1));
         chk("acc_en", acc_en, int'(mPhase == 1 && pxl_vld));
         chk("fwd_vld", fwd_vld, int'(mPhase == 2));
         chk("fwd_last", fwd_last, int'(mPhase == 2 && mB == 63));
         chk("frame_done", frame_done, int'(mDone));
         chk("fwd_shift", fwd_shift, mBw + mBh);
         if (mPhase == 1 && pxl_vld) begin
            chk("acc_row", acc_row, py / (1 << mBh));
            chk("acc_col", acc_col, px / (1 << mBw));
            chk("acc_clr", acc_clr, int'(px % (1 << mBw) == 0 && py % (1 << mBh) == 0));
            if (mBw == 1 && mBh == 2 && px == 5 && py == 9) begin
               chk("pin_5_9_row", acc_row, 2); chk("pin_5_9_col", acc_col, 2); chk("pin_5_9_clr", acc_clr, 0);
            end
            if (mBw == 1 && mBh == 2 && px == 4 && py == 8) chk("pin_4_8_clr", acc_clr, 1);
            if (mBw == 2 && mBh == 2 && px == 31 && py == 31) begin
               chk("pin_31_31_row", acc_row, 7); chk("pin_31_31_col", acc_col, 7);
            end
            if (mBw == 0 && mBh == 0 && px == 6 && py == 3) begin
               chk("pin_6_3_row", acc_row, 3); chk("pin_6_3_col", acc_col, 6); chk("pin_6_3_clr", acc_clr, 1);
            end
         end else chk("acc_clr_idle", acc_clr, 0);
         if (mPhase == 2) begin
            chk("fwd_row", fwd_row, mB / 8);
            chk("fwd_col", fwd_col, mB % 8);
         end
         if (acc_en) nAccEn++;
         if (acc_clr) nAccClr++;
         if (fwd_vld && fwd_rdy) nFwdHs++;
         mDone = 0;
         case (mPhase)
            0: if (start) begin
               mBw = cfg_blk_w_log2 > 2 ? 2 : int'(cfg_blk_w_log2);
               mBh = cfg_blk_h_log2 > 2 ? 2 : int'(cfg_blk_h_log2);
               mPhase = 1; mK = 0;
               nAccEn = 0; nAccClr = 0; nFwdHs = 0;
            end
            1: if (pxl_vld) begin
               mK++;
               if (mK == w * h) begin mPhase = 2; mB = 0; end
            end
            default: if (fwd_rdy) begin
               mB++;
               if (mB == 64) begin
                  mPhase = 0; mDone = 1;
                  lastAccEn = nAccEn; lastAccClr = nAccClr; lastFwdHs = nFwdHs;
               end
            end
         endcase
      end
   end

   task automatic startFrame(input logic [1:0] bw, input logic [1:0] bh);
      @(posedge clk);
      #1;
      cfg_blk_w_log2 = bw; cfg_blk_h_log2 = bh; start = 1;
      @(posedge clk);
      #1;
      start = 0;
   endtask

   task automatic waitDone(input int lim, input string nm);
      int n = 0;
      while (frame_done !== 1'b1 && n < lim) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk(nm, frame_done, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      // minimal frame
      startFrame(0, 0);
      waitDone(500, "min_timeout");
      chk("min_acc_en", lastAccEn, 64); chk("min_acc_clr", lastAccClr, 64);
      chk("min_fwd_hs", lastFwdHs, 64); chk("min_shift", fwd_shift, 0);
      // rectangular blocks with pixel gaps
      vldMode = 1;
      startFrame(1, 2);
      waitDone(3000, "rect_timeout");
      chk("rect_acc_en", lastAccEn, 512); chk("rect_acc_clr", lastAccClr, 64);
      chk("rect_shift", fwd_shift, 3);
      // forward backpressure, start during FWD ignored
      vldMode = 0; rdyMode = 1;
      startFrame(0, 0);
      for (int i = 0; i < 500 && fwd_vld !== 1'b1; i++) begin @(posedge clk); #2; end
      chk("bp_reach_fwd", fwd_vld, 1);
      @(posedge clk); #1 start = 1;
      repeat (5) @(posedge clk);
      #1 start = 0;
      waitDone(1000, "bp_timeout");
      chk("bp_fwd_hs", lastFwdHs, 64);
      // clamp: 3/3 behaves as 2/2, 32x32 frame
      rdyMode = 0;
      startFrame(3, 3);
      #2 chk("clamp_shift", fwd_shift, 4);
      waitDone(3000, "clamp_timeout");
      chk("clamp_acc_en", lastAccEn, 1024); chk("clamp_acc_clr", lastAccClr, 64);
      // reset mid-ACC, then a clean frame
      startFrame(1, 1);
      repeat (20) @(posedge clk);
      #1 rst_n = 0;
      #2 chk("abort_busy", busy, 0); chk("abort_shift", fwd_shift, 0);
      @(posedge clk); #1 rst_n = 1;
      repeat (3) @(posedge clk);
      startFrame(0, 0);
      waitDone(500, "rec_timeout");
      chk("rec_acc_en", lastAccEn, 64);
      // back-to-back with start held through frame_done and new cfg
      @(posedge clk);
      #1 cfg_blk_w_log2 = 0; cfg_blk_h_log2 = 0; start = 1;
      @(posedge clk);
      #1 cfg_blk_w_log2 = 1;
      waitDone(500, "b2b1_timeout");
      chk("b2b1_acc_en", lastAccEn, 64);
      @(posedge clk);
      #1 start = 0;
      #1 chk("b2b2_busy", busy, 1); chk("b2b2_shift", fwd_shift, 1);
      waitDone(1000, "b2b2_timeout");
      chk("b2b2_acc_en", lastAccEn, 128); chk("b2b2_acc_clr", lastAccClr, 64);
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
